// File: rtl/kernel_bc_fifo_stream_reader.sv
// kernel_bc_fifo_stream_reader: pops len words from an ap_fifo read port onto a valid/ready stream
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, len            begin a transfer of len words (sampled in IDLE only)
//   busy, done            busy in RUN/DONE; done pulses for one cycle at completion
//   fifo_empty_n/read/dout  FIFO read side; a pop happens when read & empty_n
//   m_valid/ready/data/last output stream; last marks the final word
module kernel_bc_fifo_stream_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty_n,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;
    logic [LEN_WIDTH-1:0] rd_rem, out_rem;
    logic [1:0] occ;
    logic [DATA_WIDTH-1:0] buf0, buf1;
    logic pop, beat;
    // fifo_read depends only on registers, so m_ready never reaches the FIFO combinationally
    assign fifo_read = (state == RUN) && (rd_rem != '0) && (occ < 2'd2);
    assign pop       = fifo_read && fifo_empty_n;
    assign m_valid   = occ != 2'd0;
    assign beat      = m_valid && m_ready;
    assign m_data    = buf0;
    assign m_last    = m_valid && (out_rem == LEN_WIDTH'(1));
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    always_comb begin
        state_next = (state == IDLE) ? (start ? ((len == '0) ? DONE : RUN) : IDLE) :
                     (state == RUN)  ? ((beat && m_last) ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end
    // buf0 is the stream head, buf1 the skid slot; a pop lands in buf0 whenever
    // the head is empty or being drained in the same cycle with nothing behind it
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_rem  <= '0;
            out_rem <= '0;
            occ     <= '0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            if (state == IDLE && start) begin
                rd_rem  <= len;
                out_rem <= len;
            end else begin
                if (pop)  rd_rem  <= rd_rem - LEN_WIDTH'(1);
                if (beat) out_rem <= out_rem - LEN_WIDTH'(1);
            end
            occ <= occ + 2'(pop) - 2'(beat);
            if (pop && (occ == 2'd0 || (occ == 2'd1 && beat))) buf0 <= fifo_dout;
            else if (beat && occ == 2'd2)                      buf0 <= buf1;
            if (pop && occ == 2'd1 && !beat) buf1 <= fifo_dout;
        end
    end
endmodule

// File: tb/tb_kernel_bc_fifo_stream_reader.sv
// tb_kernel_bc_fifo_stream_reader: table-driven check of the FIFO stream reader
module tb_kernel_bc_fifo_stream_reader;
    logic        clk = 0;
    logic        reset, start, busy, done, fifo_empty_n, fifo_read;
    logic        m_valid, m_ready, m_last, fifo_en;
    logic [31:0] len_in;
    logic [63:0] fifo_dout, m_data;
    logic [63:0] mem [32];
    int          rp = 0, wp = 0;
    int          tests = 0, fails = 0;

    typedef struct {
        int          len;
        logic [63:0] base;
        logic [15:0] epat;
        logic [15:0] rpat;
        int          exp_done;
        int          probe;
        int          probe_pops;
        int          restart_at;
    } vec_t;
    vec_t vecs [7];

    kernel_bc_fifo_stream_reader #(.DATA_WIDTH(64), .LEN_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len_in), .busy(busy), .done(done),
        .fifo_empty_n(fifo_empty_n), .fifo_read(fifo_read), .fifo_dout(fifo_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    assign fifo_dout    = mem[rp[4:0]];
    assign fifo_empty_n = (rp != wp) && fifo_en;

    always @(posedge clk) if (fifo_read && fifo_empty_n) rp <= rp + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v, input string nm);
        int k = 0, done_c = -1, rp0;
        logic prev_hold = 0;
        logic [63:0] prev_data = '0;
        wp = rp;
        for (int i = 0; i < v.len; i++) begin
            mem[wp[4:0]] = v.base + 64'(i);
            wp++;
        end
        rp0 = rp;
        @(negedge clk);
        start = 1; len_in = 32'(v.len); m_ready = 1; fifo_en = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start   = (c == v.restart_at);
            len_in  = start ? 32'd99 : 32'(v.len);
            m_ready = (c < 16) ? v.rpat[c] : 1'b1;
            fifo_en = (c < 16) ? v.epat[c] : 1'b1;
            #1;
            if (c == 0) chk({nm, " busy"}, 64'(busy), 64'd1);
            if (prev_hold) begin
                chk({nm, " hold valid"}, 64'(m_valid), 64'd1);
                chk({nm, " hold data"}, m_data, prev_data);
            end
            if (c == v.probe) begin
                chk({nm, " probe pops"}, 64'(rp - rp0), 64'(v.probe_pops));
                chk({nm, " probe read"}, 64'(fifo_read), 64'd0);
            end
            if (m_valid && m_ready) begin
                chk({nm, " data"}, m_data, v.base + 64'(k));
                chk({nm, " last"}, 64'(m_last), 64'(k == v.len - 1));
                k++;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            if (done) begin
                done_c = c;
                break;
            end
        end
        start = 0;
        chk({nm, " done cycle"}, 64'(done_c), 64'(v.exp_done));
        chk({nm, " beats"}, 64'(k), 64'(v.len));
        chk({nm, " pops"}, 64'(rp - rp0), 64'(v.len));
        @(negedge clk);
        #1;
        chk({nm, " idle busy"}, 64'(busy), 64'd0);
        chk({nm, " idle done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          len base    epat       rpat       done probe pops restart
        vecs[0] = '{4, 64'h10,  16'hFFFF, 16'hFFFF,  5, -1, 0, -1};
        vecs[1] = '{8, 64'h400, 16'hFFFF, 16'hFFC0, 14,  6, 2, -1};
        vecs[2] = '{0, 64'h0,   16'hFFFF, 16'hFFFF,  0, -1, 0, -1};
        vecs[3] = '{5, 64'h100, 16'h9249, 16'hFFFF, 14, -1, 0, -1};
        vecs[4] = '{3, 64'h500, 16'hFFFF, 16'hFFFF,  4, -1, 0,  1};
        vecs[5] = '{7, 64'h200, 16'hFFFF, 16'hAAAA, 14, -1, 0, -1};
        vecs[6] = '{1, 64'h300, 16'hFFFF, 16'hFFFF,  2, -1, 0, -1};
        reset = 1; start = 0; len_in = 0; m_ready = 0; fifo_en = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst fifo_read", 64'(fifo_read), 64'd0);
        chk("rst m_valid", 64'(m_valid), 64'd0);
        chk("rst m_last", 64'(m_last), 64'd0);
        chk("rst m_data", m_data, 64'd0);
        reset = 0;
        for (int i = 0; i < 7; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));
        wp = rp;
        for (int i = 0; i < 6; i++) begin
            mem[wp[4:0]] = 64'h700 + 64'(i);
            wp++;
        end
        @(negedge clk);
        start = 1; len_in = 6; m_ready = 1; fifo_en = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        #1;
        chk("abort m_valid", 64'(m_valid), 64'd0);
        chk("abort fifo_read", 64'(fifo_read), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        reset = 0;
        run_xfer('{3, 64'h600, 16'hFFFF, 16'hFFFF, 4, -1, 0, -1}, "after_abort");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
